// File: rtl/sam_mem_pkg.sv
// Shared constants and host FSM encoding for the SAM SRAM arbiter.
// The core has fixed priority; the host port borrows the SRAM in its idle cycles.
package sam_mem_pkg;

    localparam int              ADDR_W    = 21;
    localparam logic [20:0]     CFG_ADDR  = 21'h008FD5;
    localparam int              BOOT_WAIT = 7;

    typedef enum logic [1:0] {
        H_IDLE,
        H_SETUP,
        H_ACCESS,
        H_ACK
    } host_state_e;

endpackage

// File: rtl/sram_boot_cfg.sv
// Power-on config fetch: waits for the config byte to settle, latches its low
// two bits and then releases the core.
module sram_boot_cfg #(
    parameter int BOOT_WAIT = sam_mem_pkg::BOOT_WAIT
) (
    input  logic       clk24,
    input  logic       reset_n,
    input  logic [1:0] cfg_bits,
    output logic [1:0] scandoubler_ctrl,
    output logic       core_reset_n
);
    import sam_mem_pkg::*;

    localparam int CNT_W = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic [1:0]       scan_q;

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            scan_q <= 2'b00;
        end else if (!done_q) begin
            // Sample on the last stable-address cycle, not after it.
            if (cnt_q == CNT_W'(BOOT_WAIT - 1)) begin
                scan_q <= cfg_bits;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign scandoubler_ctrl = scan_q;
    assign core_reset_n     = done_q;

endmodule

// File: rtl/sram_host_arbiter.sv
// SRAM port owner: core has the bus whenever core_busy, the host byte port uses
// a setup/access/ack sequence in the gaps and restarts whole if preempted.
module sram_host_arbiter #(
    parameter int                ADDR_W    = sam_mem_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] CFG_ADDR  = sam_mem_pkg::CFG_ADDR,
    parameter int                BOOT_WAIT = sam_mem_pkg::BOOT_WAIT
) (
    input  logic              clk24,
    input  logic              reset_n,
    input  logic              core_busy,
    input  logic [18:0]       core_addr,
    input  logic              core_we_n,
    input  logic [7:0]        core_wdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we_n,
    output logic [7:0]        sram_dout,
    output logic              sram_oe,
    input  logic [7:0]        sram_din,
    output logic [1:0]        scandoubler_ctrl,
    output logic              core_reset_n
);
    import sam_mem_pkg::*;

    host_state_e       state_q;
    logic              addr_ok_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic              lat_we_q;
    logic [7:0]        lat_wdata_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic              sram_we_n_q;
    logic              sram_oe_q;
    logic [7:0]        sram_dout_q;
    logic              host_ack_q;
    logic [7:0]        host_rdata_q;
    logic              running;

    sram_boot_cfg #(
        .BOOT_WAIT(BOOT_WAIT)
    ) u_boot (
        .clk24            (clk24),
        .reset_n          (reset_n),
        .cfg_bits         (sram_din[1:0]),
        .scandoubler_ctrl (scandoubler_ctrl),
        .core_reset_n     (running)
    );

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            state_q      <= H_IDLE;
            addr_ok_q    <= 1'b0;
            lat_addr_q   <= '0;
            lat_we_q     <= 1'b0;
            lat_wdata_q  <= 8'h00;
            sram_addr_q  <= CFG_ADDR;
            sram_we_n_q  <= 1'b1;
            sram_oe_q    <= 1'b0;
            sram_dout_q  <= 8'h00;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 8'h00;
        end else if (!running) begin
            sram_addr_q <= CFG_ADDR;
            sram_we_n_q <= 1'b1;
            sram_oe_q   <= 1'b0;
            host_ack_q  <= 1'b0;
        end else begin
            host_ack_q  <= 1'b0;
            sram_we_n_q <= 1'b1;
            sram_oe_q   <= 1'b0;
            unique case (state_q)
                H_IDLE: begin
                    if (host_req && !core_busy) begin
                        lat_addr_q  <= host_addr;
                        lat_we_q    <= host_we;
                        lat_wdata_q <= host_wdata;
                        addr_ok_q   <= 1'b1;
                        sram_addr_q <= host_addr;
                        sram_dout_q <= host_wdata;
                        sram_oe_q   <= host_we;
                        state_q     <= H_SETUP;
                    end
                end
                H_SETUP: begin
                    if (!core_busy) begin
                        sram_addr_q <= lat_addr_q;
                        sram_dout_q <= lat_wdata_q;
                        sram_oe_q   <= lat_we_q;
                        // After preemption the address needs one settle cycle before we_n.
                        if (addr_ok_q) begin
                            sram_we_n_q <= ~lat_we_q;
                            state_q     <= H_ACCESS;
                        end else begin
                            addr_ok_q <= 1'b1;
                        end
                    end
                end
                H_ACCESS: begin
                    if (!core_busy) begin
                        sram_addr_q <= lat_addr_q;
                        sram_dout_q <= lat_wdata_q;
                        sram_oe_q   <= lat_we_q;
                        if (!lat_we_q) begin
                            host_rdata_q <= sram_din;
                        end
                        host_ack_q <= 1'b1;
                        state_q    <= H_ACK;
                    end
                end
                H_ACK: begin
                    state_q <= H_IDLE;
                end
            endcase
            if (core_busy) begin
                sram_addr_q <= {{(ADDR_W-19){1'b0}}, core_addr};
                sram_we_n_q <= core_we_n;
                sram_oe_q   <= ~core_we_n;
                sram_dout_q <= core_wdata;
                if (state_q == H_SETUP || state_q == H_ACCESS) begin
                    addr_ok_q <= 1'b0;
                    state_q   <= H_SETUP;
                end
            end
        end
    end

    assign host_ack     = host_ack_q;
    assign host_rdata   = host_rdata_q;
    assign sram_addr    = sram_addr_q;
    assign sram_we_n    = sram_we_n_q;
    assign sram_oe      = sram_oe_q;
    assign sram_dout    = sram_dout_q;
    assign core_reset_n = running;

endmodule
